// File: rtl/riscv_pipe_ctrl.sv
// Pipeline sequencer: per-stage valid bits, halt/run/step advance control,
// load-use bubble insertion, taken-branch flush, PC control and retire counting.

package riscv_pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_HALT     = 2'b00,
    MODE_RUN      = 2'b01,
    MODE_STEP     = 2'b10,
    MODE_HALT_ALT = 2'b11
  } run_mode_e;

  // What the pipeline does on the coming edge.
  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_ADVANCE,
    ACT_STALL,
    ACT_FLUSH
  } pipe_act_e;

endpackage

module riscv_pipe_ctrl
  import riscv_pipe_ctrl_pkg::*;
#(
  parameter int STAGES    = 5,
  parameter int REG_ADR_W = 5,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           mode,
  input  logic                 step_en,
  input  logic [REG_ADR_W-1:0] id_rs1,
  input  logic [REG_ADR_W-1:0] id_rs2,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  logic [REG_ADR_W-1:0] ex_rd,
  input  logic                 ex_is_load,
  input  logic                 branch_taken,
  output logic [STAGES-1:0]    stage_valid,
  output logic [STAGES-1:0]    stage_adv,
  output logic                 pc_we,
  output logic                 pc_sel_branch,
  output logic                 stall,
  output logic                 flush,
  output logic [CNT_W-1:0]     retire_cnt,
  output logic                 boot_ok
);

  run_mode_e          mode_e;
  pipe_act_e          act;
  logic               step_del;
  logic               step_pulse;
  logic               adv;
  logic               rs1_hit;
  logic               rs2_hit;
  logic               lu;
  logic               fl;
  logic               retire;
  logic [STAGES-1:0]  valid_nxt;

  assign mode_e     = run_mode_e'(mode);
  assign step_pulse = step_del & ~step_en;

  always_comb begin
    case (mode_e)
      MODE_RUN:  adv = 1'b1;
      MODE_STEP: adv = step_pulse;
      default:   adv = 1'b0;
    endcase
  end

  // A load in EX writing x0 never creates a real dependency.
  assign rs1_hit = id_uses_rs1 & (id_rs1 == ex_rd);
  assign rs2_hit = id_uses_rs2 & (id_rs2 == ex_rd);
  assign lu      = stage_valid[2] & ex_is_load & (ex_rd != '0) & stage_valid[1]
                 & (rs1_hit | rs2_hit);
  assign fl      = stage_valid[2] & branch_taken;

  // The flush kills the dependent ID instruction, so it takes priority over the bubble.
  always_comb begin
    act = ACT_HOLD;
    if (!rst && adv) begin
      if (fl)      act = ACT_FLUSH;
      else if (lu) act = ACT_STALL;
      else         act = ACT_ADVANCE;
    end
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    stage_adv     = '0;
    pc_we         = 1'b0;
    pc_sel_branch = 1'b0;
    stall         = 1'b0;
    flush         = 1'b0;
    case (act)
      ACT_ADVANCE: begin
        stage_adv = '1;
        pc_we     = 1'b1;
      end
      ACT_STALL: begin
        stage_adv      = '1;
        stage_adv[1:0] = 2'b00;
        stall          = 1'b1;
      end
      ACT_FLUSH: begin
        stage_adv     = '1;
        pc_we         = 1'b1;
        pc_sel_branch = 1'b1;
        flush         = 1'b1;
      end
      default: ;
    endcase
  end

  // Stages past EX always shift on any advance; only IF/ID/EX differ by action.
  always_comb begin
    valid_nxt = stage_valid;
    if (act != ACT_HOLD) begin
      for (int i = 3; i < STAGES; i++) valid_nxt[i] = stage_valid[i-1];
    end
    case (act)
      ACT_ADVANCE: begin
        valid_nxt[2] = stage_valid[1];
        valid_nxt[1] = stage_valid[0];
        valid_nxt[0] = 1'b1;
      end
      ACT_STALL: begin
        valid_nxt[2] = 1'b0;
      end
      ACT_FLUSH: begin
        valid_nxt[2] = 1'b0;
        valid_nxt[1] = 1'b0;
        valid_nxt[0] = 1'b1;
      end
      default: ;
    endcase
  end

  assign retire = adv & stage_valid[STAGES-1];

  // NOTE: sequential state uses non-blocking assignments so all registers
  // sample pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_valid <= '0;
      retire_cnt  <= '0;
      boot_ok     <= 1'b0;
      step_del    <= 1'b0;
    end else begin
      step_del    <= step_en;
      stage_valid <= valid_nxt;
      if (retire) begin
        retire_cnt <= retire_cnt + CNT_W'(1);
        boot_ok    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_riscv_pipe_ctrl.sv
// Scoreboard bench for riscv_pipe_ctrl: directed vectors push hand-computed
// expectations; a negedge monitor pops and compares them against the DUT.

module tb_riscv_pipe_ctrl;

  localparam int STAGES    = 5;
  localparam int REG_ADR_W = 5;
  localparam int CNT_W     = 4;

  typedef struct {
    string      name;
    logic [4:0] sv;
    logic [4:0] sadv;
    logic       pwe;
    logic       psel;
    logic       stl;
    logic       fls;
    logic [3:0] cnt;
    logic       boot;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [1:0]           mode;
  logic                 step_en;
  logic [REG_ADR_W-1:0] id_rs1, id_rs2, ex_rd;
  logic                 id_uses_rs1, id_uses_rs2, ex_is_load, branch_taken;
  logic [STAGES-1:0]    stage_valid, stage_adv;
  logic                 pc_we, pc_sel_branch, stall, flush, boot_ok;
  logic [CNT_W-1:0]     retire_cnt;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  riscv_pipe_ctrl #(.STAGES(STAGES), .REG_ADR_W(REG_ADR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .mode(mode), .step_en(step_en),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .branch_taken(branch_taken),
    .stage_valid(stage_valid), .stage_adv(stage_adv), .pc_we(pc_we),
    .pc_sel_branch(pc_sel_branch), .stall(stall), .flush(flush),
    .retire_cnt(retire_cnt), .boot_ok(boot_ok)
  );

  always #5 clk = ~clk;

  // Monitor: the DUT presents a settled output set every negedge.
  always @(negedge clk) begin
    if (q.size() != 0) begin
      mon_e = q.pop_front();
      checks++;
      if ({stage_valid, stage_adv, pc_we, pc_sel_branch, stall, flush, retire_cnt, boot_ok} !==
          {mon_e.sv, mon_e.sadv, mon_e.pwe, mon_e.psel, mon_e.stl, mon_e.fls, mon_e.cnt, mon_e.boot}) begin
        errors++;
        $display("FAIL %s: got sv=%b adv=%b pc_we=%b sel=%b stall=%b flush=%b cnt=%0d boot=%b; want sv=%b adv=%b pc_we=%b sel=%b stall=%b flush=%b cnt=%0d boot=%b",
                 mon_e.name, stage_valid, stage_adv, pc_we, pc_sel_branch, stall, flush, retire_cnt, boot_ok,
                 mon_e.sv, mon_e.sadv, mon_e.pwe, mon_e.psel, mon_e.stl, mon_e.fls, mon_e.cnt, mon_e.boot);
      end
    end
  end

  task automatic tick(input string name, input logic [4:0] sv, input logic [4:0] sadv,
                      input logic pwe, input logic psel, input logic stl, input logic fls,
                      input logic [3:0] cnt, input logic boot);
    exp_t e;
    e.name = name; e.sv = sv; e.sadv = sadv; e.pwe = pwe; e.psel = psel;
    e.stl = stl; e.fls = fls; e.cnt = cnt; e.boot = boot;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string name, input logic [4:0] sv, input logic [3:0] cnt, input logic boot);
    tick(name, sv, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, cnt, boot);
  endtask

  task automatic go(input string name, input logic [4:0] sv, input logic [3:0] cnt, input logic boot);
    tick(name, sv, 5'b11111, 1'b1, 1'b0, 1'b0, 1'b0, cnt, boot);
  endtask

  task automatic hz(input logic ld, input logic [4:0] rd, input logic u1, input logic [4:0] r1,
                    input logic u2, input logic [4:0] r2, input logic br);
    ex_is_load = ld; ex_rd = rd; id_uses_rs1 = u1; id_rs1 = r1;
    id_uses_rs2 = u2; id_rs2 = r2; branch_taken = br;
  endtask

  initial begin
    logic [4:0] prev_sv;
    logic [4:0] sv_e;
    rst = 1'b1; mode = 2'b01; step_en = 1'b0;
    hz(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    @(posedge clk);
    #1;

    // Reset held with run mode requested: combinational outputs forced low.
    idle("reset", 5'b00000, 4'd0, 1'b0);
    rst = 1'b0;

    // Free-run fill and first retires.
    for (int i = 0; i <= 15; i++) begin
      sv_e = (i >= 5) ? 5'b11111 : 5'((1 << i) - 1);
      go($sformatf("run_%0d", i), sv_e, (i > 5) ? 4'(i - 5) : 4'd0, i > 5);
    end

    // Halt for 10 cycles, with a step edge that must be ignored.
    mode = 2'b00;
    for (int k = 0; k < 10; k++) begin
      if (k == 3) step_en = 1'b1;
      if (k == 6) step_en = 1'b0;
      idle($sformatf("halt_%0d", k), 5'b11111, 4'd11, 1'b1);
    end

    // Counter wrap: 11 -> 15 -> 0.
    mode = 2'b01;
    for (int k = 0; k < 5; k++) go($sformatf("wrap_%0d", k), 5'b11111, 4'(11 + k), 1'b1);
    mode = 2'b00;
    idle("wrapped", 5'b11111, 4'd0, 1'b1);
    mode = 2'b01;

    // Load-use hazards.
    hz(1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 5'd5, 1'b0);
    tick("lu_rs2", 5'b11111, 5'b11100, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
    go("lu_bubble", 5'b11011, 4'd1, 1'b1);
    hz(1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0);
    go("lu_rd0", 5'b10111, 4'd2, 1'b1);
    hz(1'b1, 5'd7, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0);
    tick("lu_rs1", 5'b01111, 5'b11100, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3, 1'b1);
    hz(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    go("after_lu", 5'b11011, 4'd3, 1'b1);
    hz(1'b0, 5'd7, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0);
    go("no_load", 5'b10111, 4'd4, 1'b1);
    hz(1'b1, 5'd7, 1'b0, 5'd7, 1'b1, 5'd3, 1'b0);
    go("unused_rs1", 5'b01111, 4'd5, 1'b1);

    // Taken branch together with a load-use match: flush wins.
    hz(1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 5'd5, 1'b1);
    tick("flush_lu", 5'b11111, 5'b11111, 1'b1, 1'b1, 1'b0, 1'b1, 4'd5, 1'b1);
    hz(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
    go("br_ex_empty", 5'b11001, 4'd6, 1'b1);
    hz(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);

    // Reset mid-run: comb outputs drop at once, state clears on the edge.
    rst = 1'b1;
    idle("rst_mid", 5'b10011, 4'd7, 1'b1);
    rst = 1'b0; mode = 2'b10; step_en = 1'b0;
    idle("rst_done", 5'b00000, 4'd0, 1'b0);

    // Single step: three falling edges.
    prev_sv = 5'b00000;
    for (int n = 0; n < 3; n++) begin
      sv_e = {prev_sv[3:0], 1'b1};
      step_en = 1'b1;
      idle($sformatf("step_hi_%0d", n), prev_sv, 4'd0, 1'b0);
      step_en = 1'b0;
      go($sformatf("step_fall_%0d", n), prev_sv, 4'd0, 1'b0);
      idle($sformatf("step_low_%0d", n), sv_e, 4'd0, 1'b0);
      prev_sv = sv_e;
    end
    for (int k = 0; k < 3; k++) idle($sformatf("step_hold_%0d", k), 5'b00111, 4'd0, 1'b0);

    // Branch without an advance does nothing; with a step it flushes.
    hz(1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 5'd5, 1'b1);
    idle("br_no_adv", 5'b00111, 4'd0, 1'b0);
    step_en = 1'b1;
    idle("br_step_hi", 5'b00111, 4'd0, 1'b0);
    step_en = 1'b0;
    tick("br_step_flush", 5'b00111, 5'b11111, 1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0);
    hz(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    idle("br_step_after", 5'b01001, 4'd0, 1'b0);

    // Mode 11 behaves as halt even with a step edge.
    mode = 2'b11;
    step_en = 1'b1;
    idle("m11_hi", 5'b01001, 4'd0, 1'b0);
    step_en = 1'b0;
    idle("m11_fall", 5'b01001, 4'd0, 1'b0);
    idle("m11_hold", 5'b01001, 4'd0, 1'b0);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    checks++;
    errors++;
    $display("FAIL watchdog: run did not complete, want completion before 100000");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_pipe_ctrl.md
Name: riscv_pipe_ctrl

Overview:
- Parametrised pipeline sequencer for the RISC-V core; the core's next generation after the single-step, all-stages-move-together scheme.
- Owns per-stage valid bits and a global advance decision with three modes: halt, free-run, and single-step on the falling edge of `step_en`.
- Detects load-use hazards and inserts a bubble; flushes wrong-path stages on a taken branch.
- Drives stage enables and the PC write/select controls, and provides retire counting and a boot-ok flag.

Parameters:
- `STAGES`, 5: pipeline depth, minimum 3. Stage 0 = IF, 1 = ID, 2 = EX, `STAGES-1` = WB.
- `REG_ADR_W`, 5: register address width.
- `CNT_W`, 32: retire counter width.

Ports:
- `clk`  in  1  core clock.
- `rst`  in  1  reset, synchronous, active-high.
- `mode`  in  2  00 halt, 01 run, 10 step, 11 halt.
- `step_en`  in  1  step level; a falling edge requests one advance.
- `id_rs1`  in  `REG_ADR_W`  rs1 address of the instruction in ID.
- `id_rs2`  in  `REG_ADR_W`  rs2 address of the instruction in ID.
- `id_uses_rs1`  in  1  ID instruction reads rs1.
- `id_uses_rs2`  in  1  ID instruction reads rs2.
- `ex_rd`  in  `REG_ADR_W`  rd of the instruction in EX.
- `ex_is_load`  in  1  EX instruction is a load.
- `branch_taken`  in  1  EX resolved a taken branch or jump.
- `stage_valid`  out  `STAGES`  registered per-stage valid.
- `stage_adv`  out  `STAGES`  combinational per-stage capture enable.
- `pc_we`  out  1  combinational PC write enable.
- `pc_sel_branch`  out  1  combinational; PC source is the branch target.
- `stall`  out  1  combinational; load-use bubble this cycle.
- `flush`  out  1  combinational; branch flush this cycle.
- `retire_cnt`  out  `CNT_W`  registered retired-instruction count.
- `boot_ok`  out  1  registered, sticky; first instruction retired.

Behaviour:
- Reset (sync, `rst`=1 at the clock edge):
  - `stage_valid`=0, `retire_cnt`=0, `boot_ok`=0, internal `step_del`=0.
  - While `rst`=1, all combinational outputs are forced to 0.
- Step edge detect:
  - `step_del` <= `step_en` every cycle, in all modes.
  - `step_pulse` = `step_del` & ~`step_en`.
- Advance:
  - `adv` = (mode==01) | (mode==10 & `step_pulse`).
  - mode 00/11: no advance; all state held.
  - A step pulse in run or halt mode is consumed and has no extra effect.
- Hazard:
  - `lu` = `stage_valid[2]` & `ex_is_load` & (`ex_rd`!=0) & `stage_valid[1]` & ((`id_uses_rs1` & `id_rs1`==`ex_rd`) | (`id_uses_rs2` & `id_rs2`==`ex_rd`)).
- Flush:
  - `fl` = `stage_valid[2]` & `branch_taken`.
  - When both `fl` and `lu` are true, `fl` wins and `lu` is ignored.
- Outputs:
  - `flush` = `adv` & `fl`.
  - `stall` = `adv` & `lu` & ~`fl`.
- Normal advance (`adv`, no stall/flush):
  - `stage_adv` = all ones, `pc_we`=1, `pc_sel_branch`=0.
  - `stage_valid[i]` <= `stage_valid[i-1]` for i≥1; `stage_valid[0]` <= 1.
- Stall:
  - `stage_adv[1:0]`=0 and `pc_we`=0, so IF/ID hold.
  - `stage_adv[STAGES-1:2]`=1; `stage_valid[2]` <= 0 (bubble).
  - Stages ≥3 shift normally; `stage_valid[1:0]` hold.
- Flush:
  - `stage_adv` = all ones, `pc_we`=1, `pc_sel_branch`=1.
  - `stage_valid[2]` <= 0, `stage_valid[1]` <= 0, `stage_valid[0]` <= 1.
  - Stages ≥3 shift, so the branch itself proceeds to stage 3.
- No advance: `stage_adv`=0, `pc_we`=0, `pc_sel_branch`=0, `stall`=0, `flush`=0.
- Retire:
  - When `adv` & `stage_valid[STAGES-1]`, `retire_cnt` <= `retire_cnt`+1, wrapping modulo 2^`CNT_W`.
  - `boot_ok` <= 1 on the same edge and stays set until `rst`.
- Latency: from reset in run mode the first advance is cycle 1, the first retire is on advance number `STAGES`+1, and `retire_cnt`=1 is visible after that edge.
- Mode change: takes effect on the cycle it is sampled, with no internal delay. Run→halt freezes `stage_valid` exactly.
- Reset mid-operation: all valid bits are cleared on the next edge, and wrong-path/in-flight instructions are discarded.

Test Plan:
- Reset, mode=01, no hazards, `STAGES`=5 → `stage_valid` 00001, 00011, … 11111 after 5 cycles; `retire_cnt`=1 and `boot_ok`=1 after cycle 6; `retire_cnt`=10 after cycle 15.
- mode=10, `step_en` toggled 1→0 three times (each low ≥2 cycles) → exactly 3 advances; `stage_valid`=00111; holding `step_en` low produces no further advance.
- Full pipe; `ex_is_load`=1, `ex_rd`=5, `id_rs2`=5, `id_uses_rs2`=1 → `stall`=1, `pc_we`=0, `stage_adv`=11100, `stage_valid[2]`=0 next cycle; same stimulus with `ex_rd`=0 → no stall.
- Full pipe; `branch_taken`=1 together with a load-use match → `flush`=1, `stall`=0, `pc_sel_branch`=1; next `stage_valid`=11001.
- `retire_cnt` forced near wrap (`CNT_W`=4, count 15) plus one retire → `retire_cnt`=0 and `boot_ok` stays 1; mode=00 for 10 cycles → state unchanged; `rst` pulse mid-run → all outputs 0 on next edge.
